muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit implementing the RV32M instructions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the core.

- **Position in the datapath:** sits between the register-file read ports and its write port. Operands come from the two read-data outputs. The result returns through the register-file write port (`we3`/`wa3`/`wd3`).
- **Protocol:** a single-pulse start and a fixed-latency done, with `busy` used by control to stall the PC while an operation is in flight.
- **Algorithms:**
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring step per cycle.
  - Both run on operand magnitudes, with sign correction at the end.

## Interface
Parameters:
- `XLEN`, 32, operand/result width. Only 32 is supported.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse. Sampled only when the unit is idle.
- `funct3`  in  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  32  rs1 value (from register-file read port 1).
- `b`  in  32  rs2 value (from register-file read port 2).
- `rd`  in  5  destination register index.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid during it.
- `result`  out  32  registered result.
- `we`  out  1  write enable toward `we3`; equals `done && (wa != 0)`.
- `wa`  out  5  captured `rd`, toward `wa3`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `start=1` at an edge: capture `funct3`, `rd`, operand magnitudes, signs and zero-divisor flag; clear the 6-bit iteration counter; go to RUN.
  - `start=0`: stay in IDLE.
- **RUN:**
  - One iteration per edge.
  - After the 32nd iteration, the sign-corrected result is written to `result` and the state goes to DONE.
- **DONE:** `done=1` for one cycle; the next state is IDLE unconditionally.
- **`start` when not IDLE:** ignored, including in DONE. No queuing.
- **Signedness:**
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU: `a` signed, `b` unsigned.
  - MULHU/DIVU/REMU treat both as unsigned.
- **Multiply:** produces a 64-bit product.
  - MUL returns bits [31:0].
  - MULH, MULHSU and MULHU return bits [63:32].
  - The product is negated when exactly one signed operand is negative.
- **Divide:**
  - Quotient is negated when operand signs differ.
  - Remainder takes the sign of the dividend.
- **Divide by zero (`b==0`):**
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return `a` unchanged.
  - Same latency as a normal divide.
- **Overflow (DIV of 0x80000000 by 0xFFFFFFFF):**
  - Quotient is 0x80000000; REM gives 0.
  - Must fall out of the magnitude datapath; no special case is required beyond the 33-bit remainder register.
- **Result hold:** `result` and `wa` stay constant from DONE until the next accepted start.
- **x0 destination:** `rd=0` completes normally with `done=1`, `we=0`.

## Timing
- **Reset values:**
  - `busy=0`, `done=0`, `we=0`, `result=0`, `wa=0`.
  - State IDLE, counter 0.
- **Reset in any state:** aborts the operation at that edge. No `done`, no `we`.
- **Accept edge E0:** `start` is sampled high while IDLE. `busy` is high from the cycle after E0.
- **Iterations:** happen at edges E1..E32.
- **Result edge E33:** `result` is written and the state enters DONE. `done`, `we` and `result` are valid in the cycle between E33 and E34.
- **E34:** return to IDLE, `busy=0`. A new `start` may be sampled at E35.
- **Latency and throughput:**
  - Start-to-done latency is 33 cycles for every `funct3` and every operand value, including zero-divisor cases.
  - Minimum issue interval is 35 cycles.
- **Operand stability:** operands are needed only at E0. `a`/`b`/`rd` may change freely afterwards.
- **Reset and start together:** reset wins over a simultaneous `start`.

## Test plan
- **MUL/MULH:**
  - Stimulus: `a=0xFFFFFFFF`, `b=0x00000002`.
  - Required: MUL → 0xFFFFFFFE, MULH → 0xFFFFFFFF, MULHU → 0x00000001, MULHSU → 0xFFFFFFFF.
  - Each with `done` exactly 33 cycles after the accept edge.
- **DIV/REM signs:**
  - Stimulus: `a=-7` (0xFFFFFFF9), `b=2`.
  - Required: DIV → 0xFFFFFFFD, REM → 0xFFFFFFFF, DIVU → 0x7FFFFFFC, REMU → 0x00000001.
- **Corner cases:**
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM → 0.
  - DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
  - Both corner cases keep the 33-cycle latency.
- **Handshake:**
  - Stimulus: `start` held high continuously.
  - Required: accepts only at E0, E35, E70, …
  - `busy` is high for exactly 34 cycles per operation and `done` for exactly 1.
  - `rd=0` gives `done=1`, `we=0`.
  - `rd=5` gives `we=1`, `wa=5`.
- **Reset mid-operation:**
  - Stimulus: assert `reset` at iteration 10.
  - Required: next cycle `busy=0`, `result=0`, and no `done`.
  - A following MUL 3×4 → 12 completes normally.
- **Random:** 10k random operand/`funct3` pairs checked against a reference model, `result` compared at each `done`.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// both on operand magnitudes with sign correction on the final edge.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            we,
    output logic [4:0]      wa
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        wa_q, wa_d;
    logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;     // product, or dividend/quotient in low half
    logic [XLEN:0]     rem_q, rem_d;
    logic              neg_q, neg_d;     // product/quotient sign
    logic              rneg_q, rneg_d;   // remainder follows dividend sign
    logic              bzero_q, bzero_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              sgn_a_en, sgn_b_en, neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic              q_neg;

    assign sgn_a_en = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
    assign sgn_b_en = sgn_a_en && (funct3 != 3'b010);
    assign neg_a    = sgn_a_en & a[XLEN-1];
    assign neg_b    = sgn_b_en & b[XLEN-1];
    assign mag_a    = neg_a ? (~a + 1'b1) : a;
    assign mag_b    = neg_b ? (~b + 1'b1) : b;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    // A zero divisor leaves the quotient all-ones; skip the sign flip so DIV yields -1.
    assign q_neg    = neg_q & ~bzero_q;
    assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix  = q_neg ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    assign rem_fix  = rneg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        wa_d     = wa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bzero_d  = bzero_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    op_d    = funct3;
                    wa_d    = rd;
                    opb_d   = mag_b;
                    acc_d   = {{XLEN{1'b0}}, mag_a};
                    rem_d   = '0;
                    neg_d   = neg_a ^ neg_b;
                    rneg_d  = neg_a;
                    bzero_d = (b == '0);
                end
            end
            S_RUN: begin
                if (cnt_q == 6'd32) begin
                    state_d = S_DONE;
                    if (!op_q[2])
                        result_d = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                        : prod_fix[2*XLEN-1:XLEN];
                    else
                        result_d = op_q[1] ? rem_fix : quo_fix;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (!op_q[2]) begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end else if (!div_diff[XLEN]) begin
                        rem_d = div_diff;
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift;
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            wa_q     <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            wa_q     <= wa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bzero_q  <= bzero_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign we     = done && (wa_q != 5'd0);
    assign wa     = wa_q;
    assign result = result_q;

endmodule
